// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline controller.
// State encoding and register-index width.
package pipeline_controller_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational RAW hazard detection against EXE and MEM destinations.
// With forwarding only an EXE load can still cause a stall.
module hazard_detect
  import pipeline_controller_pkg::*;
#(
  parameter int FORWARD_EN = 0
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_one_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  output logic             raw_hazard
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = exe_wb_en &
    ((id_one_src & (id_rn == exe_dest)) |
     (id_two_src & (id_src2 == exe_dest)));

  assign mem_hit = mem_wb_en &
    ((id_one_src & (id_rn == mem_dest)) |
     (id_two_src & (id_src2 == mem_dest)));

  assign raw_hazard = (FORWARD_EN != 0)
    ? (exe_hit & exe_mem_read)
    : (exe_hit | mem_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline controller: memory-wait FSM, branch flush and stall counting.
// Every output is forced low while reset is asserted.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int FORWARD_EN  = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_one_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze_if,
  output logic             freeze_all,
  output logic             flush,
  output logic             mem_timeout,
  output logic [15:0]      stall_count
);

  localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        br_q, br_d;
  logic        to_q;
  logic [15:0] cnt_q;

  logic raw;
  logic mem_stall;
  logic fa, fl, hz, fi, hit;

  hazard_detect #(
    .FORWARD_EN(FORWARD_EN)
  ) u_hd (
    .id_rn       (id_rn),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_one_src  (id_one_src),
    .exe_dest    (exe_dest),
    .mem_dest    (mem_dest),
    .exe_wb_en   (exe_wb_en),
    .mem_wb_en   (mem_wb_en),
    .exe_mem_read(exe_mem_read),
    .raw_hazard  (raw)
  );

  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    state_d   = state_q;
    fa        = 1'b0;
    unique case (state_q)
      RUN: begin
        fa = mem_stall;
        if (mem_stall)
          state_d = WAIT_MEM;
        else if (branch_taken | br_q)
          state_d = FLUSH;
      end
      WAIT_MEM: begin
        fa = 1'b1;
        if (mem_ready)
          state_d = RUN;
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    fl = (branch_taken | br_q) & ~fa;
    hz = raw & ~fl;
    fi = fa | hz;
    // A branch seen while frozen waits for the first unfrozen cycle.
    br_d = fa & (br_q | branch_taken);

    wait_d = wait_q;
    if (state_d == RUN)
      wait_d = 8'd0;
    else if (state_d == WAIT_MEM && wait_q != 8'hFF)
      wait_d = wait_q + 8'd1;

    hit = fa & (({1'b0, wait_q} + 9'd1) == TO_LIM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      br_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      br_q    <= br_d;
      to_q    <= to_q | hit;
      if (fi && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign hazard      = rst & hz;
  assign freeze_if   = rst & fi;
  assign freeze_all  = rst & fa;
  assign flush       = rst & fl;
  assign mem_timeout = rst & (to_q | hit);
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized bench with a behavioural model for two controller variants.
// Instance 0: no forwarding, timeout 3; instance 1: forwarding, timeout 15.
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] id_rn, id_src2, exe_dest, mem_dest;
  logic       id_two_src, id_one_src;
  logic       exe_wb_en, mem_wb_en, exe_mem_read;
  logic       branch_taken, mem_req, mem_ready;

  logic        hz [2];
  logic        fi [2];
  logic        fa [2];
  logic        fl [2];
  logic        to [2];
  logic [15:0] sc [2];

  int n_chk  = 0;
  int n_pass = 0;

  int fe [2] = '{0, 1};
  int mt [2] = '{3, 15};

  int md [2];
  int wcnt [2];
  int pend [2];
  int tout [2];
  int scnt [2];

  always #5 clk = ~clk;

  pipeline_controller #(.FORWARD_EN(0), .MEM_TIMEOUT(3)) u0 (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_one_src(id_one_src),
    .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_read(exe_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(hz[0]), .freeze_if(fi[0]), .freeze_all(fa[0]),
    .flush(fl[0]), .mem_timeout(to[0]), .stall_count(sc[0])
  );

  pipeline_controller #(.FORWARD_EN(1), .MEM_TIMEOUT(15)) u1 (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_one_src(id_one_src),
    .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_read(exe_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(hz[1]), .freeze_if(fi[1]), .freeze_all(fa[1]),
    .flush(fl[1]), .mem_timeout(to[1]), .stall_count(sc[1])
  );

  task automatic check(input string tag, input int inst,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[u%0d] got %h want %h t=%0t",
                  tag, inst, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      md[i] = 0; wcnt[i] = 0; pend[i] = 0;
      tout[i] = 0; scnt[i] = 0;
    end
  endtask

  task automatic set_idle();
    id_rn = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    id_two_src = 0; id_one_src = 0;
    exe_wb_en = 0; mem_wb_en = 0; exe_mem_read = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Called just after a falling edge with inputs driven;
  // returns at the next falling edge.
  task automatic tick();
    int nmd [2];
    int nw [2];
    int np [2];
    int nt [2];
    int ns [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      bit me, mm, raw, stalled, e_fl, e_hz, e_fi, e_to;
      me = exe_wb_en &&
        ((id_one_src && id_rn == exe_dest) ||
         (id_two_src && id_src2 == exe_dest));
      mm = mem_wb_en &&
        ((id_one_src && id_rn == mem_dest) ||
         (id_two_src && id_src2 == mem_dest));
      raw = fe[i] != 0 ? (me && exe_mem_read) : (me || mm);
      stalled = md[i] == 1 ||
        (md[i] == 0 && mem_req && !mem_ready);
      e_fl = (branch_taken || pend[i] != 0) && !stalled;
      e_hz = raw && !e_fl;
      e_fi = stalled || e_hz;
      e_to = tout[i] != 0 || (stalled && wcnt[i] + 1 == mt[i]);
      check("hazard", i, 16'(hz[i]), 16'(e_hz));
      check("freeze_if", i, 16'(fi[i]), 16'(e_fi));
      check("freeze_all", i, 16'(fa[i]), 16'(stalled));
      check("flush", i, 16'(fl[i]), 16'(e_fl));
      check("mem_timeout", i, 16'(to[i]), 16'(e_to));
      check("stall_count", i, sc[i], 16'(scnt[i]));
      if (md[i] == 0)
        nmd[i] = (mem_req && !mem_ready) ? 1 :
                 (branch_taken || pend[i] != 0) ? 2 : 0;
      else if (md[i] == 1)
        nmd[i] = mem_ready ? 0 : 1;
      else
        nmd[i] = 0;
      np[i] = stalled ? int'(pend[i] != 0 || branch_taken) : 0;
      if (nmd[i] == 1) nw[i] = wcnt[i] < 255 ? wcnt[i] + 1 : 255;
      else if (nmd[i] == 0) nw[i] = 0;
      else nw[i] = wcnt[i];
      nt[i] = int'(e_to);
      ns[i] = (e_fi && scnt[i] < 65535) ? scnt[i] + 1 : scnt[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      md[i] = nmd[i]; wcnt[i] = nw[i]; pend[i] = np[i];
      tout[i] = nt[i]; scnt[i] = ns[i];
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_hazard", i, 16'(hz[i]), 16'd0);
      check("rst_freeze_if", i, 16'(fi[i]), 16'd0);
      check("rst_freeze_all", i, 16'(fa[i]), 16'd0);
      check("rst_flush", i, 16'(fl[i]), 16'd0);
      check("rst_timeout", i, 16'(to[i]), 16'd0);
      check("rst_stall_count", i, sc[i], 16'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic raw_exe3();
    set_idle();
    id_rn = 4'd3; id_one_src = 1; exe_dest = 4'd3; exe_wb_en = 1;
  endtask

  initial begin
    set_idle();
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      check("init_freeze_if", i, 16'(fi[i]), 16'd0);
      check("init_stall_count", i, sc[i], 16'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // RAW on an EXE ALU result, then on an EXE load
    raw_exe3();
    #1;
    check("raw_nofwd_hz", 0, 16'(hz[0]), 16'd1);
    check("raw_fwd_alu_hz", 1, 16'(hz[1]), 16'd0);
    tick();
    check("raw_nofwd_cnt", 0, sc[0], 16'd1);
    exe_mem_read = 1;
    #1;
    check("raw_fwd_load_hz", 1, 16'(hz[1]), 16'd1);
    tick();

    // Four not-ready cycles then ready: five frozen cycles
    set_idle();
    reset_mid();
    mem_req = 1;
    for (int k = 0; k < 4; k++) tick();
    mem_ready = 1;
    tick();
    set_idle();
    #1;
    check("memwait_cnt", 0, sc[0], 16'd5);
    check("memwait_cnt", 1, sc[1], 16'd5);
    check("memwait_fa", 0, 16'(fa[0]), 16'd0);
    tick();

    // Branch beats a RAW hazard
    raw_exe3();
    branch_taken = 1;
    #1;
    check("br_flush", 0, 16'(fl[0]), 16'd1);
    check("br_hazard", 0, 16'(hz[0]), 16'd0);
    tick();
    set_idle();
    tick();

    // Timeout threshold, then reset while waiting
    reset_mid();
    mem_req = 1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("timeout_step", 0, 16'(to[0]), 16'(k >= 3));
      tick();
    end
    reset_mid();
    set_idle();
    tick();

    // Branch during memory wait is replayed once unfrozen
    mem_req = 1;
    tick();
    branch_taken = 1;
    tick();
    branch_taken = 0;
    tick();
    mem_ready = 1;
    tick();
    set_idle();
    #1;
    check("late_flush", 0, 16'(fl[0]), 16'd1);
    check("late_flush", 1, 16'(fl[1]), 16'd1);
    tick();
    tick();

    for (int n = 0; n < 3000; n++) begin
      id_rn        = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      exe_dest     = 4'($urandom_range(0, 3));
      mem_dest     = 4'($urandom_range(0, 3));
      id_one_src   = 1'($urandom_range(0, 1));
      id_two_src   = 1'($urandom_range(0, 1));
      exe_wb_en    = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_read = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 99) < 15);
      mem_req      = ($urandom_range(0, 99) < 35);
      mem_ready    = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 199) == 0) reset_mid();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
